// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_pkg : shared types, field positions and constants for fetch/IF-ID
// Revision 1.0
// ============================================================================
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_FULL = 2'd1,
        S_KILL = 2'd2
    } fetch_state_e;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // R-type instructions write rd, everything else writes rt.
    function automatic logic [4:0] wr_reg(input logic [31:0] instr);
        return (instr[OP_MSB:OP_LSB] == OP_RTYPE) ? instr[RD_MSB:RD_LSB]
                                                   : instr[RT_MSB:RT_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_if : imem bus, decode control and IF/ID outputs of the fetch stage
// Revision 1.0
// ============================================================================
interface instr_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [4:0]  dir_a;
    logic [4:0]  dir_b;
    logic [4:0]  dir_wra;
    logic [15:0] imd;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_data,
        output imem_req, imem_addr, id_valid, id_instr, id_pc4,
               dir_a, dir_b, dir_wra, imd
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_data,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc4,
               dir_a, dir_b, dir_wra, imd
    );
endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// fetch_skid_buf : one-entry {instr, pc4} park slot used while decode stalls
// Revision 1.0
// ============================================================================
module fetch_skid_buf (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        load_i,
    input  wire logic        unload_i,
    input  wire logic        clear_i,
    input  wire logic [31:0] instr_i,
    input  wire logic [31:0] pc4_i,
    output logic             valid_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc4_o
);
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
        end else if (clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC, one-outstanding imem fetch FSM and IF/ID pipeline register
// Revision 1.0
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    instr_fetch_if.master bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         live_q;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc4_q, id_pc4_d;

    logic         skid_load, skid_unload, skid_clear, skid_valid;
    logic [31:0]  skid_instr, skid_pc4;

    logic         w_req;
    logic         w_ack;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect_pc;

    // live_q holds the request low for one cycle after reset release.
    assign w_req         = live_q && (state_q != S_FULL);
    assign w_ack         = bus.imem_ack && w_req;
    assign w_pc_plus4    = pc_q + 32'd4;
    assign w_redirect_pc = bus.redirect_pc & ~32'h3;

    fetch_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (bus.imem_data),
        .pc4_i    (w_pc_plus4),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc4_o    (skid_pc4)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            live_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
            id_pc4_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            live_q     <= 1'b1;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc4_d    = id_pc4_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (id_valid_q && !bus.stall) begin
            id_valid_d = 1'b0;
        end

        if (bus.redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP;
            skid_clear = 1'b0 | 1'b1;
            tgt_d      = w_redirect_pc;
            // With a request still in flight the address must stay stable, so the
            // new PC waits in tgt_q until the stale response has been absorbed.
            if (w_req && !w_ack) begin
                state_d = S_KILL;
            end else begin
                state_d = S_REQ;
                pc_d    = w_redirect_pc;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (w_ack) begin
                        pc_d = w_pc_plus4;
                        if (!bus.stall || !id_valid_q) begin
                            id_valid_d = 1'b1;
                            id_instr_d = bus.imem_data;
                            id_pc4_d   = w_pc_plus4;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!bus.stall && skid_valid) begin
                        id_valid_d  = 1'b1;
                        id_instr_d  = skid_instr;
                        id_pc4_d    = skid_pc4;
                        skid_unload = 1'b1;
                        state_d     = S_REQ;
                    end
                end
                S_KILL: begin
                    if (w_ack) begin
                        pc_d    = tgt_q;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc4    = id_pc4_q;
    assign bus.dir_a     = id_instr_q[RS_MSB:RS_LSB];
    assign bus.dir_b     = id_instr_q[RT_MSB:RT_LSB];
    assign bus.dir_wra   = wr_reg(id_instr_q);
    assign bus.imd       = id_instr_q[IMM_MSB:IMM_LSB];
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Revision 1.0
// ============================================================================
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_n2;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_if bus  ();
    instr_fetch_if bus2 ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i  (clk),
        .rst_ni (rst_n2),
        .bus    (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    initial begin
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        bus.stall  = 1'b0; bus.redirect  = 1'b0; bus.redirect_pc  = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
        bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0;
        bus2.imem_ack = 1'b0; bus2.imem_data = 32'h0;

        repeat (3) step();
        check("rst_valid", 32'(bus.id_valid), 32'h0);
        check("rst_req",   32'(bus.imem_req), 32'h0);
        check("rst_instr", bus.id_instr, 32'h0);
        check("rst_pc4",   bus.id_pc4, 32'h0);
        check("rst_addr",  bus.imem_addr, 32'h0);

        // Reset release and back-to-back single-cycle fetches
        rst_n = 1'b1;
        step();
        check("t1_req_up", 32'(bus.imem_req), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), bus.imem_addr, 32'(4 * i));
            bus.imem_ack  = 1'b1;
            bus.imem_data = mem_word(32'(4 * i));
            step();
            check($sformatf("t1_pc4_%0d", i),   bus.id_pc4, 32'(4 * i + 4));
            check($sformatf("t1_valid%0d", i),  32'(bus.id_valid), 32'h1);
            check($sformatf("t1_instr%0d", i),  bus.id_instr, mem_word(32'(4 * i)));
        end

        // Stall while a word returns: park it, then drain
        check("t2_addr", bus.imem_addr, 32'h10);
        bus.stall     = 1'b1;
        bus.imem_data = mem_word(32'h10);
        step();
        bus.imem_ack = 1'b0;
        check("t2_req_full",  32'(bus.imem_req), 32'h0);
        check("t2_hold_instr", bus.id_instr, mem_word(32'hC));
        check("t2_hold_valid", 32'(bus.id_valid), 32'h1);
        step();
        step();
        check("t2_req_full3", 32'(bus.imem_req), 32'h0);
        check("t2_hold3",     bus.id_instr, mem_word(32'hC));
        bus.stall = 1'b0;
        step();
        check("t2_drain_instr", bus.id_instr, mem_word(32'h10));
        check("t2_drain_pc4",   bus.id_pc4, 32'h14);
        check("t2_drain_valid", 32'(bus.id_valid), 32'h1);
        check("t2_resume_req",  32'(bus.imem_req), 32'h1);
        check("t2_resume_addr", bus.imem_addr, 32'h14);
        step();
        check("t2_bubble_valid", 32'(bus.id_valid), 32'h0);
        check("t2_bubble_instr", bus.id_instr, mem_word(32'h10));

        // Redirect with a request pending; late ACK is discarded
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step();
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        check("t3_flush_valid", 32'(bus.id_valid), 32'h0);
        check("t3_flush_instr", bus.id_instr, 32'h0);
        check("t3_kill_req",    32'(bus.imem_req), 32'h1);
        check("t3_kill_addr",   bus.imem_addr, 32'h14);
        step();
        check("t3_kill_addr2",  bus.imem_addr, 32'h14);
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem_word(32'h14);
        step();
        bus.imem_ack = 1'b0;
        check("t3_drop_valid", 32'(bus.id_valid), 32'h0);
        check("t3_drop_instr", bus.id_instr, 32'h0);
        check("t3_new_addr",   bus.imem_addr, 32'h100);
        check("t3_new_req",    32'(bus.imem_req), 32'h1);

        // Redirect + ACK + STALL in the same cycle
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem_word(32'h100);
        step();
        check("t4_pre_instr", bus.id_instr, mem_word(32'h100));
        check("t4_pre_addr",  bus.imem_addr, 32'h104);
        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        bus.imem_data   = mem_word(32'h104);
        step();
        bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
        check("t4_valid", 32'(bus.id_valid), 32'h0);
        check("t4_instr", bus.id_instr, 32'h0);
        check("t4_addr",  bus.imem_addr, 32'h200);
        check("t4_req",   32'(bus.imem_req), 32'h1);

        // Decode field slicing
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h0022_1820;
        step();
        check("t5_r_wra", 32'(bus.dir_wra), 32'h3);
        check("t5_r_imd", 32'(bus.imd), 32'h1820);
        check("t5_r_a",   32'(bus.dir_a), 32'h1);
        check("t5_r_b",   32'(bus.dir_b), 32'h2);
        bus.imem_data = 32'h8C41_FFFC;
        step();
        bus.imem_ack = 1'b0;
        check("t5_lw_wra", 32'(bus.dir_wra), 32'h1);
        check("t5_lw_a",   32'(bus.dir_a), 32'h2);
        check("t5_lw_b",   32'(bus.dir_b), 32'h1);
        check("t5_lw_imd", 32'(bus.imd), 32'hFFFC);
        check("t5_addr",   bus.imem_addr, 32'h208);

        // Async reset in S_KILL, then PC wrap from FFFF_FFFC
        rst_n2 = 1'b1;
        step();
        check("t6_req0",  32'(bus2.imem_req), 32'h1);
        check("t6_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.redirect    = 1'b1;
        bus2.redirect_pc = 32'h0000_0040;
        step();
        bus2.redirect = 1'b0;
        check("t6_kill_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        #2;
        rst_n2 = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus2.id_valid), 32'h0);
        check("t6_rst_req",   32'(bus2.imem_req), 32'h0);
        step();
        rst_n2 = 1'b1;
        step();
        check("t6_rel_req",  32'(bus2.imem_req), 32'h1);
        check("t6_rel_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_ack  = 1'b1;
        bus2.imem_data = mem_word(32'hFFFF_FFFC);
        step();
        bus2.imem_ack = 1'b0;
        check("t6_wrap_addr",  bus2.imem_addr, 32'h0);
        check("t6_wrap_pc4",   bus2.id_pc4, 32'h0);
        check("t6_wrap_valid", 32'(bus2.id_valid), 32'h1);
        check("t6_wrap_instr", bus2.id_instr, mem_word(32'hFFFF_FFFC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
